// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROL over log2(N) registered stages with valid/ready flow control.
// Optional sticky (shifted-out OR) output is enabled by defining PIPELINED_BARREL_SHIFTER_STICKY_EN.
module pipelined_barrel_shifter #(
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_amt,
    input  logic [1:0]    up_op,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
    ,
    output logic          down_sticky
`endif
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_width
        $error("pipelined_barrel_shifter: N must be a power of two and at least 2");
    end

    function automatic logic [N-1:0] stage_shift(input logic [N-1:0] d, input logic [1:0] op,
                                                 input int unsigned s);
        case (op)
            OP_SLL:  stage_shift = d << s;
            OP_SRL:  stage_shift = d >> s;
            OP_SRA:  stage_shift = $unsigned($signed(d) >>> s);
            default: stage_shift = (d << s) | (d >> (N - s));
        endcase
    endfunction

    logic [SW-1:0] valid_q, valid_d;
    logic [N-1:0]  data_q [SW];
    logic [N-1:0]  data_d [SW];
    logic [SW-1:0] amt_q  [SW];
    logic [SW-1:0] amt_d  [SW];
    logic [1:0]    op_q   [SW];
    logic [1:0]    op_d   [SW];

    logic [SW-1:0] in_v;
    logic [N-1:0]  in_d [SW];
    logic [SW-1:0] in_a [SW];
    logic [1:0]    in_o [SW];

    logic [SW-1:0] rdy;
    logic [SW-1:0] mask;
    logic [N-1:0]  shifted;

    // Stage k's source: the upstream port for stage 0, otherwise the previous stage's registers.
    always_comb begin
        in_v    = '0;
        in_d    = '{default: '0};
        in_a    = '{default: '0};
        in_o    = '{default: '0};
        in_v[0] = up_valid;
        in_d[0] = up_data;
        in_a[0] = up_amt;
        in_o[0] = up_op;
        for (int k = 1; k < SW; k++) begin
            in_v[k] = valid_q[k-1];
            in_d[k] = data_q[k-1];
            in_a[k] = amt_q[k-1];
            in_o[k] = op_q[k-1];
        end
    end

    // A stage can load when down_ready is high or some stage at or after it is empty.
    always_comb begin
        rdy     = '0;
        mask    = '0;
        shifted = '0;
        valid_d = valid_q;
        data_d  = data_q;
        amt_d   = amt_q;
        op_d    = op_q;
        for (int k = 0; k < SW; k++) begin
            mask    = ~((SW'(1) << k) - SW'(1));
            rdy[k]  = down_ready | ((valid_q & mask) != mask);
            shifted = in_a[k][k] ? stage_shift(in_d[k], in_o[k], 32'(1) << k) : in_d[k];
            if (rdy[k]) begin
                valid_d[k] = in_v[k];
                if (in_v[k]) begin
                    data_d[k] = shifted;
                    amt_d[k]  = in_a[k];
                    op_d[k]   = in_o[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < SW; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                op_q[k]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < SW; k++) begin
                data_q[k] <= data_d[k];
                amt_q[k]  <= amt_d[k];
                op_q[k]   <= op_d[k];
            end
        end
    end

    assign up_ready   = rdy[0];
    assign down_valid = valid_q[SW-1];
    assign down_data  = data_q[SW-1];

`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
    // Bits dropped off either end by one stage; rotation never drops anything.
    function automatic logic stage_lost(input logic [N-1:0] d, input logic [1:0] op,
                                        input int unsigned s);
        logic [N-1:0] low_mask;
        low_mask = (N'(1) << s) - N'(1);
        case (op)
            OP_SLL:         stage_lost = |(d >> (N - s));
            OP_SRL, OP_SRA: stage_lost = |(d & low_mask);
            default:        stage_lost = 1'b0;
        endcase
    endfunction

    logic [SW-1:0] sticky_q, sticky_d;
    logic [SW-1:0] in_s;

    always_comb begin
        in_s     = '0;
        sticky_d = sticky_q;
        for (int k = 1; k < SW; k++) begin
            in_s[k] = sticky_q[k-1];
        end
        for (int k = 0; k < SW; k++) begin
            if (rdy[k] && in_v[k]) begin
                sticky_d[k] = in_s[k] | (in_a[k][k] & stage_lost(in_d[k], in_o[k], 32'(1) << k));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign down_sticky = sticky_q[SW-1];
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter: directed cases plus randomized traffic with backpressure.
// Optional sticky output is checked when PIPELINED_BARREL_SHIFTER_STICKY_EN is defined.
module tb_pipelined_barrel_shifter;

    localparam int N  = 8;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          up_valid = 1'b0;
    logic          up_ready;
    logic [N-1:0]  up_data = '0;
    logic [SW-1:0] up_amt = '0;
    logic [1:0]    up_op = '0;
    logic          down_valid;
    logic          down_ready;
    logic [N-1:0]  down_data;
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
    logic          down_sticky;
`endif

    pipelined_barrel_shifter #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_amt     (up_amt),
        .up_op      (up_op),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data)
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
        ,
        .down_sticky(down_sticky)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] data;
        logic         sticky;
        int           acc_cyc;
        bit           lat;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    bit   bp_rand = 1'b0;
    bit   dr_fixed = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: each result bit is picked straight from the operand by the mode's rule.
    function automatic void ref_shift(input logic [N-1:0] d, input int amt, input int op,
                                      output logic [N-1:0] r, output logic st);
        r  = '0;
        st = 1'b0;
        for (int i = 0; i < N; i++) begin
            case (op)
                0:       r[i] = (i >= amt) ? d[i-amt] : 1'b0;
                1:       r[i] = (i + amt < N) ? d[i+amt] : 1'b0;
                2:       r[i] = (i + amt < N) ? d[i+amt] : d[N-1];
                default: r[i] = d[(i - amt + N) % N];
            endcase
            if (op == 0 && i >= N - amt) st = st | d[i];
            if ((op == 1 || op == 2) && i < amt) st = st | d[i];
        end
    endfunction

    task automatic send(input logic [N-1:0] d, input int amt, input int op, input bit lat,
                        input bit use_exp, input logic [N-1:0] exp_d);
        logic [N-1:0] r;
        logic         st;
        bit           done;
        done = 1'b0;
        ref_shift(d, amt, op, r, st);
        if (use_exp) r = exp_d;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            up_valid = 1'b1;
            up_data  = d;
            up_amt   = amt[SW-1:0];
            up_op    = op[1:0];
            #1;
            if (up_ready) begin
                q.push_back('{r, st, cyc, lat});
                done = 1'b1;
            end
        end
        chk("accept_within_bound", {31'b0, done}, 32'd1);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        up_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        down_ready = 1'b1;
        forever begin
            @(posedge clk);
            #3;
            down_ready = bp_rand ? ($urandom_range(0, 3) != 0) : dr_fixed;
        end
    end

    // Monitor: samples mid low-phase, pops an expectation on every output transfer.
    initial begin
        exp_t         e;
        bit           hold;
        logic [N-1:0] held;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            #2;
            if (hold) begin
                chk("stall_valid_held", {31'b0, down_valid}, 32'd1);
                chk("stall_data_held", {24'b0, down_data}, {24'b0, held});
            end
            hold = down_valid && !down_ready;
            held = down_data;
            if (down_valid && down_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_output", {31'b0, down_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("result_data", {24'b0, down_data}, {24'b0, e.data});
`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
                    chk("result_sticky", {31'b0, down_sticky}, {31'b0, e.sticky});
`endif
                    if (e.lat) chk("latency", cyc - e.acc_cyc, SW);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] d;
        int           a, o;

        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_down_valid", {31'b0, down_valid}, 32'd0);
        chk("reset_down_data", {24'b0, down_data}, 32'd0);
        chk("reset_up_ready", {31'b0, up_ready}, 32'd1);

        send(8'b1001_0110, 3, 0, 1'b1, 1'b1, 8'b1011_0000);
        send(8'b1001_0110, 3, 1, 1'b1, 1'b1, 8'b0001_0010);
        send(8'b1001_0110, 3, 2, 1'b1, 1'b1, 8'b1111_0010);
        send(8'b1001_0110, 3, 3, 1'b1, 1'b1, 8'b1011_0100);
        idle(6);

        for (int i = 0; i < N; i++) send(8'h01, i, 0, 1'b1, 1'b1, 8'h01 << i);
        idle(6);

        send(8'b1001_0110, 3, 1, 1'b1, 1'b0, '0);
        send(8'b1001_0110, 1, 1, 1'b1, 1'b0, '0);
        send(8'b1001_0110, 3, 0, 1'b1, 1'b0, '0);
        send(8'b1001_0110, 5, 3, 1'b1, 1'b0, '0);
        send(8'b1100_0001, 0, 2, 1'b1, 1'b1, 8'b1100_0001);
        idle(6);

        dr_fixed = 1'b0;
        idle(2);
        send(8'h81, 1, 2, 1'b0, 1'b0, '0);
        send(8'h3c, 2, 3, 1'b0, 1'b0, '0);
        send(8'hf0, 4, 1, 1'b0, 1'b0, '0);
        @(negedge clk);
        up_valid = 1'b1;
        up_data  = 8'h5a;
        up_amt   = 3'd6;
        up_op    = 2'd0;
        #1;
        chk("bp_up_ready_low", {31'b0, up_ready}, 32'd0);
        @(negedge clk);
        up_data = 8'hff;
        #1;
        chk("bp_up_ready_still_low", {31'b0, up_ready}, 32'd0);
        dr_fixed = 1'b1;
        send(8'h5a, 6, 0, 1'b0, 1'b0, '0);
        idle(8);

        send(8'h77, 2, 1, 1'b0, 1'b0, '0);
        send(8'h99, 1, 2, 1'b0, 1'b0, '0);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_down_valid", {31'b0, down_valid}, 32'd0);
        chk("midreset_up_ready", {31'b0, up_ready}, 32'd1);
        q.delete();
        #1 rst_n = 1'b1;
        idle(6);
        chk("post_reset_quiet", {31'b0, down_valid}, 32'd0);

        bp_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            d = N'($urandom);
            a = $urandom_range(0, N - 1);
            o = $urandom_range(0, 3);
            send(d, a, o, 1'b0, 1'b0, '0);
        end
        idle(1);
        bp_rand = 1'b0;
        dr_fixed = 1'b1;
        for (int t = 0; t < 500 && q.size() != 0; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("drain_empty", q.size(), 32'd0);
        chk("final_up_ready", {31'b0, up_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
